button_poll_ctrl: RTL
=====================

Name: button_poll_ctrl

Overview:
- Avalon-MM master that sequences the push-button PIO slave.
- Every POLL_DIV cycles it reads the PIO data register at offset 0.
- It debounces each bit over DEBOUNCE_CNT consecutive samples and emits a clean level plus one-cycle press/release pulses to the counter logic.
- Sits between the button PIO and the counter core, so software never has to poll.

Parameters:
- NB_BTN, 2, number of button bits taken from readdata[NB_BTN-1:0].
- POLL_DIV, 50000, cycles between poll starts (1 ms at 50 MHz); must be >= 8.
- DEBOUNCE_CNT, 4, consecutive identical samples required to change a debounced level; range 1..15.
- ACTIVE_LOW, 1, 1 = raw 0 means pressed (bits inverted before filtering).
- TIMEOUT, 255, max cycles waiting on waitrequest before the read is abandoned.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = polling active; 0 = finish current read, then idle.
- avm_address  out  2  PIO register offset; always 0.
- avm_read  out  1  Avalon read strobe.
- avm_readdata  in  32  PIO read data.
- avm_waitrequest  in  1  slave stall.
- btn_state  out  NB_BTN  debounced level, 1 = pressed.
- btn_press  out  NB_BTN  one-cycle pulse on 0->1 of btn_state.
- btn_release  out  NB_BTN  one-cycle pulse on 1->0 of btn_state.
- poll_err  out  1  sticky; set on read timeout, cleared only by reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - avm_read=0, avm_address=0.
  - btn_state, btn_press, btn_release = 0; poll_err=0.
  - Divider=0; all debounce counters=0; last-sample register=0 (after polarity correction); FSM=IDLE.
- Divider: free-running 0..POLL_DIV-1 while enable=1; held at 0 while enable=0. tick=1 when the divider equals POLL_DIV-1.
- FSM states and transitions:
  - IDLE -> READ when tick=1 and enable=1.
  - READ: avm_read=1, avm_address=0.
    - When avm_waitrequest=0 in a cycle: latch s = avm_readdata[NB_BTN-1:0] (inverted if ACTIVE_LOW), go to FILTER.
    - If the wait counter reaches TIMEOUT: set poll_err, discard the sample, go to IDLE (no filter update).
    - Wait counter clears on READ entry.
  - FILTER: single cycle, per bit i:
    - if s[i] == last[i]: cnt[i] = min(cnt[i]+1, DEBOUNCE_CNT); else cnt[i] = 1.
    - last[i] = s[i].
    - If the new cnt[i] >= DEBOUNCE_CNT and s[i] != btn_state[i]: btn_state[i] toggles next cycle and the matching press/release bit pulses for exactly that cycle.
    - Then go to IDLE.
- Latency: a new level appears 1 cycle after the FILTER of the DEBOUNCE_CNT-th equal sample.
- avm_read is held steady while waitrequest=1 (Avalon rule); the address never changes.
- enable falling during READ: the read completes normally. Divider reset only takes effect in IDLE.
- tick during READ or FILTER: ignored, never queued. POLL_DIV >= 8 guarantees no overlap unless waitrequest stalls.
- Several bits may change in the same FILTER; their pulses are simultaneous.
- Reset mid-read: avm_read drops in the next cycle; no pulses are generated.
- Counters saturate; no wrap-around.

Decomposition:
- Shared package button_pkg:
  - FSM state enum {IDLE, READ, FILTER}.
  - PIO_DATA_OFFSET = 0.
  - Debounce-counter width constant (4 bits).
- Sub-module btn_debounce_bit: one bit's cnt/last/state/press/release, instantiated NB_BTN times with a common sample_valid strobe.
- Top level keeps the divider, FSM, timeout counter and Avalon signals.

Test Plan:
- Reset/idle: reset high 3 cycles, then enable=1, waitrequest=0, readdata=0x3 (released, ACTIVE_LOW) -> first avm_read at cycle POLL_DIV after reset release; btn_state stays 00; no pulses.
- Clean press: readdata=0x2 held (bit0 pressed), POLL_DIV=8, DEBOUNCE_CNT=4 -> btn_state[0] rises 1 cycle after the 4th FILTER; btn_press=01 for exactly 1 cycle; release by readdata=0x3 -> btn_release=01 after 4 more polls.
- Bounce: samples 0x2,0x3,0x2,0x2,0x2,0x2 -> no change until the 4th consecutive 0x2 (6th poll); exactly one press pulse.
- Wait states: waitrequest=1 for 5 cycles per read -> avm_read and address stable throughout; sample taken on the waitrequest=0 cycle; poll_err=0.
- Timeout: TIMEOUT=10, waitrequest stuck at 1 -> avm_read drops after 10 cycles, poll_err=1 and stays 1; next tick retries; filter state unchanged.
- Simultaneous/reset: readdata=0x0 (both pressed) -> btn_press=11 in one cycle. Assert reset mid-READ -> avm_read=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button poll controller and its
// per-bit debounce filter.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      FILTER = 2'd2
   } poll_state_t;

   localparam logic [1:0]  PIO_DATA_OFFSET = 2'd0;
   localparam int unsigned DEB_CNT_W       = 4;

endpackage

// File: rtl/btn_debounce_bit.sv
// Debounce filter for one button bit: counts consecutive identical samples and
// flips the clean level once the run length reaches DEBOUNCE_CNT.
module btn_debounce_bit
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_valid,
   input  logic sample,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEBOUNCE_CNT);
   localparam logic [DEB_CNT_W-1:0] CNT_ONE = DEB_CNT_W'(1);

   logic [DEB_CNT_W-1:0] cnt_r;
   logic [DEB_CNT_W-1:0] cnt_nxt_s;
   logic                 last_r;
   logic                 level_r;
   logic                 press_r;
   logic                 release_r;
   logic                 toggle_s;

   // Saturating run-length of identical samples and the resulting level change
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (sample == last_r) begin
         cnt_nxt_s = (cnt_r >= CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
      end else begin
         cnt_nxt_s = CNT_ONE;
      end
      toggle_s = (cnt_nxt_s >= CNT_MAX) && (sample != level_r);
   end

   // Filter state advances only on the sample strobe; edge pulses last one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r     <= '0;
         last_r    <= 1'b0;
         level_r   <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
      end else begin
         press_r   <= 1'b0;
         release_r <= 1'b0;
         if (sample_valid) begin
            cnt_r  <= cnt_nxt_s;
            last_r <= sample;
            if (toggle_s) begin
               level_r   <= sample;
               press_r   <= sample;
               release_r <= ~sample;
            end
         end
      end
   end

   assign level         = level_r;
   assign press_pulse   = press_r;
   assign release_pulse = release_r;

endmodule

// File: rtl/button_poll_ctrl.sv
// Avalon-MM master that periodically reads the button PIO data register and
// turns the raw bits into debounced levels plus press/release pulses.
module button_poll_ctrl
   import button_pkg::*;
#(
   parameter int unsigned NB_BTN       = 2,
   parameter int unsigned POLL_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [1:0]        avm_address,
   output logic              avm_read,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   output logic [NB_BTN-1:0] btn_state,
   output logic [NB_BTN-1:0] btn_press,
   output logic [NB_BTN-1:0] btn_release,
   output logic              poll_err
);

   localparam int unsigned      DIV_W     = $clog2(POLL_DIV);
   localparam int unsigned      WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(POLL_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   poll_state_t        state_r;
   poll_state_t        state_nxt_s;
   logic [DIV_W-1:0]   div_r;
   logic [WAIT_W-1:0]  wait_r;
   logic [NB_BTN-1:0]  raw_s;
   logic [NB_BTN-1:0]  sample_r;
   logic               tick_s;
   logic               accept_s;
   logic               timeout_s;
   logic               read_r;
   logic               read_nxt_s;
   logic               err_r;
   logic               err_nxt_s;
   logic               sample_valid_s;
   logic               unused_readdata_s;

   assign tick_s         = (div_r == DIV_LAST);
   assign accept_s       = (state_r == READ) && !avm_waitrequest;
   assign timeout_s      = (state_r == READ) && avm_waitrequest && (wait_r == WAIT_LAST);
   assign sample_valid_s = (state_r == FILTER);
   assign raw_s          = ACTIVE_LOW ? ~avm_readdata[NB_BTN-1:0] : avm_readdata[NB_BTN-1:0];
   assign unused_readdata_s = ^avm_readdata[31:NB_BTN];

   // Poll divider; a disabled controller only parks it once the bus is idle
   always_ff @(posedge clk) begin
      if (reset) begin
         div_r <= '0;
      end else if (!enable && (state_r == IDLE)) begin
         div_r <= '0;
      end else if (tick_s) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Wait-state counter, cleared whenever no read is outstanding
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_r <= '0;
      end else if (state_r != READ) begin
         wait_r <= '0;
      end else begin
         wait_r <= wait_r + WAIT_W'(1);
      end
   end

   // Next-state logic; ticks outside IDLE are dropped rather than queued
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (tick_s && enable) begin
               state_nxt_s = READ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: begin
            if (!avm_waitrequest) begin
               state_nxt_s = FILTER;
            end else if (timeout_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = READ;
            end
         end
         FILTER:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered bus strobe and sticky error flag
   always_comb begin
      read_nxt_s = (state_nxt_s == READ);
      err_nxt_s  = err_r | timeout_s;
   end

   // State, registered outputs and the polarity-corrected sample latch
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         read_r   <= 1'b0;
         err_r    <= 1'b0;
         sample_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         read_r  <= read_nxt_s;
         err_r   <= err_nxt_s;
         if (accept_s) begin
            sample_r <= raw_s;
         end else begin
            sample_r <= sample_r;
         end
      end
   end

   for (genvar i = 0; i < NB_BTN; i++) begin : g_bit
      btn_debounce_bit #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_bit (
         .clk           (clk),
         .reset         (reset),
         .sample_valid  (sample_valid_s),
         .sample        (sample_r[i]),
         .level         (btn_state[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

   assign avm_address = PIO_DATA_OFFSET;
   assign avm_read    = read_r;
   assign poll_err    = err_r;

endmodule
